// File: rtl/intensity_pkg.sv
// Shared definitions for consumers of the 4-bit proximity intensity level.
package intensity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] MAX_LEVEL      = 4'd7;
    localparam logic [7:0] DUTY_PER_LEVEL = 8'd32;

    // Move cur one step toward tgt, landing exactly on tgt when closer than a step.
    function automatic logic [7:0] slew_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt,
                                               input logic [7:0] step);
        logic [7:0] nxt;
        if (tgt > cur) begin
            if ((tgt - cur) < step) nxt = tgt;
            else                    nxt = cur + step;
        end else if (cur > tgt) begin
            if ((cur - tgt) < step) nxt = tgt;
            else                    nxt = cur - step;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus free-running 8-bit PWM period counter.
module pwm_timebase #(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] period_cnt,
    output logic       tick,
    output logic       period_start
);

    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r;
    logic [7:0]    period_r;

    assign tick         = (presc_r == PRESC_LAST);
    assign period_start = tick && (period_r == 8'd255);
    assign period_cnt   = period_r;

    // Prescaler wrap produces the tick that advances the period counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r  <= '0;
            period_r <= 8'd0;
        end else begin
            if (tick) begin
                presc_r  <= '0;
                period_r <= period_r + 8'd1;
            end else begin
                presc_r  <= presc_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/intensity_pwm.sv
// Debounced intensity level slewed into a glitch-free PWM actuator drive.
module intensity_pwm #(
    parameter int PRESCALE       = 8,
    parameter int STABLE_SAMPLES = 3,
    parameter int RAMP_PERIODS   = 16,
    parameter int STEP           = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] intensity,
    input  logic       enable,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic       settled
);

    import intensity_pkg::*;

    localparam int            RW          = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_PERIODS - 1);
    localparam logic [3:0]    STABLE_LAST = 4'(STABLE_SAMPLES);
    localparam logic [7:0]    STEP_V      = 8'(STEP);

    logic [7:0]    period_cnt_s;
    logic          tick_s;
    logic          period_start_s;
    logic          unused_tick_s;
    logic [3:0]    sync1_r, sync2_r;
    logic [3:0]    sample_s;
    logic [3:0]    cand_r;
    logic [3:0]    stable_cnt_r;
    logic [7:0]    target_r;
    logic [7:0]    duty_r;
    logic [7:0]    active_duty_r;
    logic [RW-1:0] ramp_cnt_r;
    logic          pwm_r;
    logic          settled_r;
    state_t        state_r;

    pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
        .clk          (clk),
        .reset_n      (reset_n),
        .period_cnt   (period_cnt_s),
        .tick         (tick_s),
        .period_start (period_start_s)
    );

    assign unused_tick_s = tick_s;
    assign pwm_out       = pwm_r;
    assign duty          = duty_r;
    assign settled       = settled_r;

    // Clamp the synchronised level to the closest valid step.
    always_comb begin
        sample_s = (sync2_r > MAX_LEVEL) ? MAX_LEVEL : sync2_r;
    end

    // Two-flop synchroniser for the level coming from the derived-clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 4'd0;
            sync2_r <= 4'd0;
        end else begin
            sync1_r <= intensity;
            sync2_r <= sync1_r;
        end
    end

    // Once-per-period debounce; a level is accepted after enough equal samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_r       <= 4'd0;
            stable_cnt_r <= 4'd0;
            target_r     <= 8'd0;
        end else begin
            if (period_start_s) begin
                if (sample_s == cand_r) begin
                    if (stable_cnt_r < STABLE_LAST) stable_cnt_r <= stable_cnt_r + 4'd1;
                end else begin
                    cand_r       <= sample_s;
                    stable_cnt_r <= 4'd1;
                end
            end
            if (stable_cnt_r == STABLE_LAST) target_r <= {4'd0, cand_r} * DUTY_PER_LEVEL;
        end
    end

    // Enable/slew state machine; dropping enable clears the duty on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            duty_r     <= 8'd0;
            settled_r  <= 1'b0;
            ramp_cnt_r <= '0;
        end else if (!enable) begin
            state_r    <= IDLE;
            duty_r     <= 8'd0;
            settled_r  <= 1'b0;
            ramp_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r    <= RAMP;
                    duty_r     <= 8'd0;
                    settled_r  <= 1'b0;
                    ramp_cnt_r <= '0;
                end
                RAMP: begin
                    if (duty_r == target_r) begin
                        state_r   <= HOLD;
                        settled_r <= 1'b1;
                    end else if (period_start_s) begin
                        if (ramp_cnt_r == RAMP_LAST) begin
                            ramp_cnt_r <= '0;
                            duty_r     <= slew_toward(duty_r, target_r, STEP_V);
                        end else begin
                            ramp_cnt_r <= ramp_cnt_r + RW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (duty_r != target_r) begin
                        state_r    <= RAMP;
                        settled_r  <= 1'b0;
                        ramp_cnt_r <= '0;
                    end else begin
                        settled_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    duty_r     <= 8'd0;
                    settled_r  <= 1'b0;
                    ramp_cnt_r <= '0;
                end
            endcase
        end
    end

    // Compare duty is frozen for a whole period so pulses never change mid-period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_duty_r <= 8'd0;
            pwm_r         <= 1'b0;
        end else if (!enable) begin
            active_duty_r <= 8'd0;
            pwm_r         <= 1'b0;
        end else begin
            if (period_start_s) active_duty_r <= duty_r;
            pwm_r <= (period_cnt_s < active_duty_r);
        end
    end

endmodule

// File: tb/tb_intensity_pwm.sv
// Period-level scoreboard bench for intensity_pwm with a one-clock PWM tick.
module tb_intensity_pwm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] intensity = 4'd0;
    logic       enable = 1'b0;
    logic       pwm_out;
    logic [7:0] duty;
    logic       settled;

    typedef struct {
        int         win;
        logic [7:0] duty;
        logic       settled;
        int         pwm_cnt;
    } rec_t;

    rec_t sb_q[$];
    rec_t obs_q[$];

    int total = 0;
    int bad   = 0;
    int win   = 0;
    int m_duty, m_target, m_cand, m_cnt, m_ad;

    always #5 clk = ~clk;

    intensity_pwm #(
        .PRESCALE       (1),
        .STABLE_SAMPLES (3),
        .RAMP_PERIODS   (1),
        .STEP           (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .intensity (intensity),
        .enable    (enable),
        .pwm_out   (pwm_out),
        .duty      (duty),
        .settled   (settled)
    );

    function automatic int slew(input int d, input int t);
        if (t - d >= 8) return d + 8;
        if (d - t >= 8) return d - 8;
        return t;
    endfunction

    task automatic model_reset();
        m_duty = 0; m_target = 0; m_cand = 0; m_cnt = 0; m_ad = 0;
    endtask

    // Reference behaviour at the end of a 256-clock period.
    task automatic model_boundary(input int lvl, input bit en);
        int s;
        s = (lvl > 7) ? 7 : lvl;
        if (en) begin
            m_ad   = m_duty;
            m_duty = slew(m_duty, m_target);
        end else begin
            m_ad   = 0;
            m_duty = 0;
        end
        if (s == m_cand) begin
            if (m_cnt < 3) m_cnt++;
        end else begin
            m_cand = s;
            m_cnt  = 1;
        end
        if (m_cnt == 3) m_target = m_cand * 32;
    endtask

    // Run one PWM period: push expected, observe duty/settled mid-period and pulse width.
    task automatic do_period(input int lvl, input bit en);
        rec_t e, o;
        intensity = 4'(lvl);
        enable    = en;
        if (!en) begin
            m_duty = 0;
            m_ad   = 0;
        end
        win++;
        e.win = win; e.duty = 8'(m_duty); e.settled = en && (m_duty == m_target); e.pwm_cnt = m_ad;
        sb_q.push_back(e);
        o.win = win; o.duty = 8'd0; o.settled = 1'b0; o.pwm_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_out === 1'b1) o.pwm_cnt++;
            if (i == 128) begin
                o.duty    = duty;
                o.settled = settled;
            end
            @(negedge clk);
        end
        obs_q.push_back(o);
        model_boundary(lvl, en);
    endtask

    task automatic test_reset();
        rec_t e, o;
        int guard;
        repeat (3) @(negedge clk);
        total += 3;
        if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset pwm_out: got %b want 0", pwm_out); end
        if (duty !== 8'd0)    begin bad++; $display("FAIL reset duty: got %0d want 0", duty); end
        if (settled !== 1'b0) begin bad++; $display("FAIL reset settled: got %b want 0", settled); end
        reset_n = 1'b1;
        model_reset();
        guard = 0;
        while (m_duty != 96 && guard < 40) begin
            do_period(3, 1'b1);
            guard++;
        end
        repeat (2) do_period(3, 1'b1);
        intensity = 4'd3;
        enable    = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (pwm_out !== 1'(m_ad > 9)) begin bad++; $display("FAIL pre_reset pwm_out: got %b want %0d", pwm_out, m_ad > 9); end
        #2 reset_n = 1'b0;
        #1;
        total += 3;
        if (pwm_out !== 1'b0) begin bad++; $display("FAIL async_reset pwm_out: got %b want 0", pwm_out); end
        if (duty !== 8'd0)    begin bad++; $display("FAIL async_reset duty: got %0d want 0", duty); end
        if (settled !== 1'b0) begin bad++; $display("FAIL async_reset settled: got %b want 0", settled); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        do_period(0, 1'b1);
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front();
            total += 3;
            if (o.duty !== e.duty)       begin bad++; $display("FAIL reset_seq duty win%0d: got %0d want %0d", e.win, o.duty, e.duty); end
            if (o.settled !== e.settled) begin bad++; $display("FAIL reset_seq settled win%0d: got %b want %b", e.win, o.settled, e.settled); end
            if (o.pwm_cnt != e.pwm_cnt)  begin bad++; $display("FAIL reset_seq pwm width win%0d: got %0d want %0d", e.win, o.pwm_cnt, e.pwm_cnt); end
        end
    endtask

    task automatic test_ramp_up();
        rec_t e, o;
        repeat (33) do_period(7, 1'b1);
        total++;
        if (m_duty != 224) begin bad++; $display("FAIL ramp_up model end: got %0d want 224", m_duty); end
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front();
            total += 3;
            if (o.duty !== e.duty)       begin bad++; $display("FAIL ramp_up duty win%0d: got %0d want %0d", e.win, o.duty, e.duty); end
            if (o.settled !== e.settled) begin bad++; $display("FAIL ramp_up settled win%0d: got %b want %b", e.win, o.settled, e.settled); end
            if (o.pwm_cnt != e.pwm_cnt)  begin bad++; $display("FAIL ramp_up pwm width win%0d: got %0d want %0d", e.win, o.pwm_cnt, e.pwm_cnt); end
        end
    endtask

    task automatic test_glitch_reject();
        rec_t e, o;
        for (int k = 0; k < 6; k++) do_period((k % 2 == 0) ? 3 : 4, 1'b1);
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front();
            total += 3;
            if (o.duty !== e.duty)       begin bad++; $display("FAIL toggle duty win%0d: got %0d want %0d", e.win, o.duty, e.duty); end
            if (o.settled !== e.settled) begin bad++; $display("FAIL toggle settled win%0d: got %b want %b", e.win, o.settled, e.settled); end
            if (o.pwm_cnt != e.pwm_cnt)  begin bad++; $display("FAIL toggle pwm width win%0d: got %0d want %0d", e.win, o.pwm_cnt, e.pwm_cnt); end
        end
    endtask

    task automatic test_ramp_down();
        rec_t e, o;
        repeat (25) do_period(2, 1'b1);
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front();
            total += 3;
            if (o.duty !== e.duty)       begin bad++; $display("FAIL ramp_down duty win%0d: got %0d want %0d", e.win, o.duty, e.duty); end
            if (o.settled !== e.settled) begin bad++; $display("FAIL ramp_down settled win%0d: got %b want %b", e.win, o.settled, e.settled); end
            if (o.pwm_cnt != e.pwm_cnt)  begin bad++; $display("FAIL ramp_down pwm width win%0d: got %0d want %0d", e.win, o.pwm_cnt, e.pwm_cnt); end
        end
    endtask

    task automatic test_clamp_reaim();
        rec_t e, o;
        int guard;
        guard = 0;
        while (m_duty != 96 && guard < 40) begin
            do_period(12, 1'b1);
            guard++;
        end
        repeat (8) do_period(3, 1'b1);
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front();
            total += 3;
            if (o.duty !== e.duty)       begin bad++; $display("FAIL reaim duty win%0d: got %0d want %0d", e.win, o.duty, e.duty); end
            if (o.settled !== e.settled) begin bad++; $display("FAIL reaim settled win%0d: got %b want %b", e.win, o.settled, e.settled); end
            if (o.pwm_cnt != e.pwm_cnt)  begin bad++; $display("FAIL reaim pwm width win%0d: got %0d want %0d", e.win, o.pwm_cnt, e.pwm_cnt); end
        end
    endtask

    task automatic test_enable_drop();
        rec_t e, o;
        int guard;
        guard = 0;
        while (m_duty != 160 && guard < 40) begin
            do_period(7, 1'b1);
            guard++;
        end
        intensity = 4'd7;
        enable    = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                total += 2;
                if (duty !== 8'(m_duty))      begin bad++; $display("FAIL drop pre duty: got %0d want %0d", duty, m_duty); end
                if (pwm_out !== 1'(m_ad > 99)) begin bad++; $display("FAIL drop pre pwm_out: got %b want %0d", pwm_out, m_ad > 99); end
                enable = 1'b0;
            end
            if (i == 101) begin
                total += 3;
                if (pwm_out !== 1'b0) begin bad++; $display("FAIL drop pwm_out: got %b want 0", pwm_out); end
                if (duty !== 8'd0)    begin bad++; $display("FAIL drop duty: got %0d want 0", duty); end
                if (settled !== 1'b0) begin bad++; $display("FAIL drop settled: got %b want 0", settled); end
            end
            @(negedge clk);
        end
        model_boundary(7, 1'b0);
        repeat (4) do_period(7, 1'b1);
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front(); o = obs_q.pop_front();
            total += 3;
            if (o.duty !== e.duty)       begin bad++; $display("FAIL enable_drop duty win%0d: got %0d want %0d", e.win, o.duty, e.duty); end
            if (o.settled !== e.settled) begin bad++; $display("FAIL enable_drop settled win%0d: got %b want %b", e.win, o.settled, e.settled); end
            if (o.pwm_cnt != e.pwm_cnt)  begin bad++; $display("FAIL enable_drop pwm width win%0d: got %0d want %0d", e.win, o.pwm_cnt, e.pwm_cnt); end
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_glitch_reject();
        test_ramp_down();
        test_clamp_reaim();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
